// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if
//   Groups the raw pad inputs and the conditioned outputs of the button
//   conditioner into one bundle.
//   btn_in      : raw pad inputs, asynchronous, active-high
//   btn_level   : debounced level
//   btn_press   : one-cycle pulse on an accepted 0->1
//   btn_release : one-cycle pulse on an accepted 1->0
//   master: whoever drives the pads and consumes the outputs.
//   slave : the conditioner itself.
interface btn_conditioner_if #(
  parameter int NUM_BTN = 2
);
  logic [NUM_BTN-1:0] btn_in;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Synchronises, debounces and edge-detects NUM_BTN independent push
//   buttons (bit 0 = btnL, bit 1 = btnR at the top level). Each channel
//   produces a clean level plus one-cycle press and release pulses.
//
// Ports
//   clk    : system clock (100 MHz)
//   rst_n  : asynchronous active-low reset
//   bus    : btn_conditioner_if.slave (btn_in in; btn_level, btn_press,
//            btn_release out)
//
// Optional feature
//   BTN_REPEAT_EN : when defined, a held button emits an extra btn_press
//   REPEAT_DELAY cycles after the initial press, then every REPEAT_PERIOD
//   cycles while it stays held. When undefined no repeat logic exists.
//
// Per-channel states
//   state       | meaning
//   ------------+--------------------------------------------------
//   IDLE        | level 0, input low
//   ARM_PRESS   | level 0, input high, counting stable samples
//   HELD        | level 1, input high
//   ARM_RELEASE | level 1, input low, counting stable samples
module btn_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input logic            clk,
  input logic            rst_n,
  btn_conditioner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    ARM_PRESS   = 2'b01,
    HELD        = 2'b11,
    ARM_RELEASE = 2'b10
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  // The sample that moves IDLE->ARM counts as the first stable cycle, so
  // acceptance happens when the counter is about to reach DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 2 ** 24) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES out of range 2..2^24");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NUM_BTN-1:0] sync_1;
  logic [NUM_BTN-1:0] sync_2;
  state_t             state [NUM_BTN];
  logic [CW-1:0]      cnt   [NUM_BTN];
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rel;

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]      rpt_cnt [NUM_BTN];
  // Set once the first (delayed) repeat has fired; selects the period.
  logic [NUM_BTN-1:0] rpt_started;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= bus.btn_in;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
`ifdef BTN_REPEAT_EN
        rpt_cnt[i] <= '0;
`endif
      end
      level <= '0;
      press <= '0;
      rel   <= '0;
`ifdef BTN_REPEAT_EN
      rpt_started <= '0;
`endif
    end else begin
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state[i])
          IDLE: begin
            if (sync_2[i]) begin
              state[i] <= ARM_PRESS;
              cnt[i]   <= '0;
            end
          end
          ARM_PRESS: begin
            if (!sync_2[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i] <= HELD;
              cnt[i]   <= '0;
              level[i] <= 1'b1;
              press[i] <= 1'b1;
`ifdef BTN_REPEAT_EN
              rpt_cnt[i]     <= '0;
              rpt_started[i] <= 1'b0;
`endif
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          HELD: begin
            if (!sync_2[i]) begin
              state[i] <= ARM_RELEASE;
              cnt[i]   <= '0;
            end
`ifdef BTN_REPEAT_EN
            // Only counts while genuinely held; ARM_RELEASE freezes it.
            else if (rpt_cnt[i] == (rpt_started[i] ? RPT_NEXT : RPT_FIRST)) begin
              rpt_cnt[i]     <= '0;
              rpt_started[i] <= 1'b1;
              press[i]       <= 1'b1;
            end else begin
              rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
            end
`endif
          end
          ARM_RELEASE: begin
            if (sync_2[i]) begin
              state[i] <= HELD;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
              level[i] <= 1'b0;
              rel[i]   <= 1'b1;
`ifdef BTN_REPEAT_EN
              rpt_cnt[i]     <= '0;
              rpt_started[i] <= 1'b0;
`endif
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;

endmodule
